// File: rtl/regfile_write_arbiter.sv
// Two-source write arbiter in front of a single register-table write port.
// Each source owns a one-entry hold buffer; the older entry wins, ties use a round-robin pointer.
module regfile_write_arbiter #(
  parameter int NUM_REGS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_wr_valid,
  output logic        alu_wr_ready,
  input  logic [4:0]  alu_wr_addr,
  input  logic [31:0] alu_wr_data,
  input  logic        mem_wr_valid,
  output logic        mem_wr_ready,
  input  logic [4:0]  mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  output logic        rf_write,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [31:0] pending_mask,
  output logic        err_oob,
  output logic [15:0] wr_count
);

  // Relative age of the two held entries; only meaningful while both are valid.
  typedef enum logic [1:0] {
    AGE_TIE,
    AGE_ALU_OLDER,
    AGE_MEM_OLDER
  } age_e;

  logic        alu_valid_q, alu_valid_d;
  logic [4:0]  alu_addr_q,  alu_addr_d;
  logic [31:0] alu_data_q,  alu_data_d;
  logic        mem_valid_q, mem_valid_d;
  logic [4:0]  mem_addr_q,  mem_addr_d;
  logic [31:0] mem_data_q,  mem_data_d;
  age_e        age_q, age_d;
  logic        rr_alu_first_q, rr_alu_first_d;
  logic        err_oob_q, err_oob_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic alu_grant, mem_grant, tie_grant;
  logic alu_cap, mem_cap, alu_keep, mem_keep;
  logic alu_in_range, mem_in_range;

  assign alu_in_range = int'(alu_addr_q) < NUM_REGS;
  assign mem_in_range = int'(mem_addr_q) < NUM_REGS;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (alu_valid_q && mem_valid_q) begin
      case (age_q)
        AGE_ALU_OLDER: alu_grant = 1'b1;
        AGE_MEM_OLDER: mem_grant = 1'b1;
        default: begin
          alu_grant = rr_alu_first_q;
          mem_grant = !rr_alu_first_q;
        end
      endcase
    end else begin
      alu_grant = alu_valid_q;
      mem_grant = mem_valid_q;
    end
  end

  assign tie_grant = alu_valid_q && mem_valid_q && (age_q == AGE_TIE);

  // Ready depends only on registered state, so no input reaches a ready combinationally.
  assign alu_wr_ready = !alu_valid_q || alu_grant;
  assign mem_wr_ready = !mem_valid_q || mem_grant;

  assign alu_cap  = alu_wr_valid && alu_wr_ready;
  assign mem_cap  = mem_wr_valid && mem_wr_ready;
  assign alu_keep = alu_valid_q && !alu_grant;
  assign mem_keep = mem_valid_q && !mem_grant;

  // Out-of-range entries still take their grant slot to drain, but never reach the port.
  always_comb begin
    rf_write = 1'b0;
    rf_addr  = '0;
    rf_data  = '0;
    if (alu_grant && alu_in_range) begin
      rf_write = 1'b1;
      rf_addr  = alu_addr_q;
      rf_data  = alu_data_q;
    end else if (mem_grant && mem_in_range) begin
      rf_write = 1'b1;
      rf_addr  = mem_addr_q;
      rf_data  = mem_data_q;
    end
  end

  always_comb begin
    pending_mask = '0;
    if (alu_valid_q && alu_in_range) pending_mask = pending_mask | (32'd1 << alu_addr_q);
    if (mem_valid_q && mem_in_range) pending_mask = pending_mask | (32'd1 << mem_addr_q);
  end

  always_comb begin
    alu_valid_d = alu_keep || alu_cap;
    alu_addr_d  = alu_cap ? alu_wr_addr : alu_addr_q;
    alu_data_d  = alu_cap ? alu_wr_data : alu_data_q;
    mem_valid_d = mem_keep || mem_cap;
    mem_addr_d  = mem_cap ? mem_wr_addr : mem_addr_q;
    mem_data_d  = mem_cap ? mem_wr_data : mem_data_q;

    // A held entry is older than anything captured alongside it at this edge.
    if (alu_keep && mem_cap)       age_d = AGE_ALU_OLDER;
    else if (mem_keep && alu_cap)  age_d = AGE_MEM_OLDER;
    else if (alu_keep && mem_keep) age_d = age_q;
    else                           age_d = AGE_TIE;

    rr_alu_first_d = tie_grant ? !rr_alu_first_q : rr_alu_first_q;
    err_oob_d      = err_oob_q
                   || (alu_cap && (int'(alu_wr_addr) >= NUM_REGS))
                   || (mem_cap && (int'(mem_wr_addr) >= NUM_REGS));
    wr_count_d     = wr_count_q + {15'd0, rf_write};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_q    <= 1'b0;
      alu_addr_q     <= '0;
      alu_data_q     <= '0;
      mem_valid_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      age_q          <= AGE_TIE;
      rr_alu_first_q <= 1'b0;
      err_oob_q      <= 1'b0;
      wr_count_q     <= '0;
    end else begin
      alu_valid_q    <= alu_valid_d;
      alu_addr_q     <= alu_addr_d;
      alu_data_q     <= alu_data_d;
      mem_valid_q    <= mem_valid_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      age_q          <= age_d;
      rr_alu_first_q <= rr_alu_first_d;
      err_oob_q      <= err_oob_d;
      wr_count_q     <= wr_count_d;
    end
  end

  assign err_oob  = err_oob_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a per-cycle vector table plus
// hand-written streaming, reset-mid-operation and counter-wrap sequences.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wr_valid, mem_wr_valid;
  logic        alu_wr_ready, mem_wr_ready;
  logic [4:0]  alu_wr_addr, mem_wr_addr;
  logic [31:0] alu_wr_data, mem_wr_data;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] pending_mask;
  logic        err_oob;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NUM_REGS(26)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wr_valid(alu_wr_valid), .alu_wr_ready(alu_wr_ready),
    .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .pending_mask(pending_mask), .err_oob(err_oob), .wr_count(wr_count)
  );

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    logic        e_ar;
    logic        e_mr;
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_wr_valid = av; alu_wr_addr = aa; alu_wr_data = ad;
    mem_wr_valid = mv; mem_wr_addr = ma; mem_wr_data = md;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " rf_write"}, 32'(rf_write), 32'd0);
    check({tag, " rf_addr"},  32'(rf_addr),  32'd0);
    check({tag, " rf_data"},  rf_data,       32'd0);
    check({tag, " pending"},  pending_mask,  32'd0);
    check({tag, " alu_rdy"},  32'(alu_wr_ready), 32'd1);
    check({tag, " mem_rdy"},  32'(mem_wr_ready), 32'd1);
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Per-cycle vectors: inputs driven this cycle, outputs expected in the same cycle.
    vecs[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 1'b1, 16'd0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b1, 5'd3, 32'hDEADBEEF, 32'h8,   1'b1, 1'b1, 16'd0, 1'b0};
    vecs[2]  = '{1'b1, 5'd5, 32'h1,        1'b1, 5'd5, 32'h2,
                 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 1'b1, 16'd1, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b1, 5'd5, 32'h2,        32'h20,  1'b0, 1'b1, 16'd1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b1, 5'd5, 32'h1,        32'h20,  1'b1, 1'b1, 16'd2, 1'b0};
    vecs[5]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,
                 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 1'b1, 16'd3, 1'b0};
    vecs[6]  = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,
                 1'b1, 5'd1, 32'h11,       32'h6,   1'b1, 1'b0, 16'd3, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h66,
                 1'b1, 5'd2, 32'h22,       32'h14,  1'b0, 1'b1, 16'd4, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b1, 5'd4, 32'h44,       32'h50,  1'b1, 1'b0, 16'd5, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b1, 5'd6, 32'h66,       32'h40,  1'b1, 1'b1, 16'd6, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd30, 32'h123,
                 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 1'b1, 16'd7, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 1'b1, 16'd7, 1'b1};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 1'b1, 16'd7, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    check_idle("reset");
    check("reset wr_count", 32'(wr_count), 32'd0);
    check("reset err_oob",  32'(err_oob),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
      check($sformatf("v%0d rf_write", i), 32'(rf_write),     32'(vecs[i].e_wr));
      check($sformatf("v%0d rf_addr", i),  32'(rf_addr),      32'(vecs[i].e_addr));
      check($sformatf("v%0d rf_data", i),  rf_data,           vecs[i].e_data);
      check($sformatf("v%0d pending", i),  pending_mask,      vecs[i].e_pend);
      check($sformatf("v%0d alu_rdy", i),  32'(alu_wr_ready), 32'(vecs[i].e_ar));
      check($sformatf("v%0d mem_rdy", i),  32'(mem_wr_ready), 32'(vecs[i].e_mr));
      check($sformatf("v%0d wr_count", i), 32'(wr_count),     32'(vecs[i].e_cnt));
      check($sformatf("v%0d err_oob", i),  32'(err_oob),      32'(vecs[i].e_err));
    end

    // Both buffers full, then reset pulled low between clock edges.
    @(negedge clk);
    drive(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd11, 32'hBBBB);
    @(posedge clk);
    #2;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("full pending", pending_mask, 32'h0000_0C00);
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    check("midrst wr_count", 32'(wr_count), 32'd0);
    check("midrst err_oob",  32'(err_oob),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("postrst");
    check("postrst wr_count", 32'(wr_count), 32'd0);

    // ALU streaming with valid held high: one write per cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) drive(1'b1, 5'(i + 1), 32'h1000 + 32'(i), 1'b0, 5'd0, 32'd0);
      else       drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check($sformatf("stream%0d alu_rdy", i), 32'(alu_wr_ready), 32'd1);
      if (i >= 1 && i <= 8) begin
        check($sformatf("stream%0d rf_write", i), 32'(rf_write), 32'd1);
        check($sformatf("stream%0d rf_addr", i),  32'(rf_addr),  32'(i));
        check($sformatf("stream%0d rf_data", i),  rf_data,       32'h1000 + 32'(i - 1));
      end else begin
        check($sformatf("stream%0d rf_write", i), 32'(rf_write), 32'd0);
      end
    end
    check("stream wr_count", 32'(wr_count), 32'd8);

    // Counter wrap: 65535 writes to reach 16'hFFFF, then one more.
    do_reset();
    for (int n = 0; n < 65535; n++) begin
      @(negedge clk);
      drive(1'b1, 5'd1, 32'(n), 1'b0, 5'd0, 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("wrap at ffff", 32'(wr_count), 32'h0000_FFFF);
    check("wrap idle rf_write", 32'(rf_write), 32'd0);
    drive(1'b1, 5'd2, 32'hCAFE, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("wrap last rf_write", 32'(rf_write), 32'd1);
    check("wrap last rf_data",  rf_data,       32'h0000_CAFE);
    @(negedge clk);
    check("wrap to zero", 32'(wr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: NUM_REGS, 26, number of implemented register-table entries; legal addresses are 0..NUM_REGS-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 alu_wr_valid  input  1  ALU writeback request.
REQ-005 alu_wr_ready  output  1  ALU request accepted when valid&ready at a rising edge.
REQ-006 alu_wr_addr  input  5  ALU destination register.
REQ-007 alu_wr_data  input  32  ALU writeback data.
REQ-008 mem_wr_valid  input  1  load writeback request.
REQ-009 mem_wr_ready  output  1  load request accepted when valid&ready at a rising edge.
REQ-010 mem_wr_addr  input  5  load destination register.
REQ-011 mem_wr_data  input  32  load writeback data.
REQ-012 rf_write  output  1  write enable to the register table write port.
REQ-013 rf_addr  output  5  register table write address.
REQ-014 rf_data  output  32  register table write data.
REQ-015 pending_mask  output  32  bit i = 1 while any held entry targets register i.
REQ-016 err_oob  output  1  sticky: an accepted request had address >= NUM_REGS.
REQ-017 wr_count  output  16  number of writes issued on rf_write, wraps.

Function
REQ-018 Each source shall own one hold buffer {valid, addr, data, age}; capture on valid&ready.
REQ-019 xx_wr_ready shall be 1 when that buffer is empty or is granted in the current cycle (drain-and-refill in one cycle); no combinational path from any input to any ready.
REQ-020 Grant: if one buffer valid, it wins; if both valid, the older (captured at an earlier edge) wins.
REQ-021 Tie (both captured at same edge): winner chosen by 1-bit round-robin pointer (reset value = mem first); pointer toggles only after a tie grant.
REQ-022 rf_write/rf_addr/rf_data shall be driven combinationally from the granted buffer; the grant drains that buffer at the next edge.
REQ-023 Latency: request accepted at edge E0 with no contention -> rf_write=1 in cycle E0..E1 -> table written at E1; one write per cycle maximum.
REQ-024 Throughput: a single source streaming with valid held high shall achieve one write per cycle.
REQ-025 Two entries to the same address shall be written in age order, so the younger value is final.
REQ-026 Entries with addr >= NUM_REGS shall be accepted, never asserted on rf_write, drained as if granted, and set err_oob.
REQ-027 rf_addr/rf_data shall be 0 whenever rf_write=0.
REQ-028 pending_mask shall be the OR of one-hot(addr) of all valid in-range buffers; out-of-range entries contribute nothing.
REQ-029 wr_count shall increment by 1 per cycle with rf_write=1; 16'hFFFF wraps to 0.
REQ-030 err_oob shall clear only on reset.

Reset
REQ-031 rst_n low shall asynchronously clear both buffers, age info, rr pointer (mem first), err_oob, wr_count; outputs read rf_write=0, rf_addr=0, rf_data=0, pending_mask=0, ready=1 for both sources.
REQ-032 Reset asserted mid-operation shall discard held entries with no partial write; first request after release takes normal latency.

Verification
REQ-033 Single ALU write addr=3 data=32'hDEADBEEF -> next cycle rf_write=1, rf_addr=3, rf_data=32'hDEADBEEF, pending_mask=32'h8 in that cycle, wr_count=1 after.
REQ-034 ALU (addr 5, data 1) and mem (addr 5, data 2) accepted same edge after reset -> mem written first, ALU second; final value 1, rr pointer toggled.
REQ-035 Mem accepted at E0, ALU at E1, both held -> mem written in first write cycle regardless of rr pointer; ALU next.
REQ-036 ALU streams 8 requests with valid held high, mem idle -> 8 consecutive rf_write cycles, alu_wr_ready stays 1.
REQ-037 mem request addr=30 -> accepted, no rf_write, err_oob=1 and stays 1 until rst_n pulse.
REQ-038 Both buffers full, rst_n pulsed low mid-cycle -> outputs clear immediately, no write; wr_count at 16'hFFFF plus one write -> 0.
